mem_port_arbiter: RTL

Shares the single byte-wide synchronous memory between the multicycle MIPS core (the controller's byte-serial fetch and lw/sw data accesses) and the external program loader. Uses a req/ack handshake per requester, with core priority by default. A core lock keeps the 4-byte instruction fetch atomic, and a starvation counter guarantees the loader a slot. Sits between the core's memory interface, the loader, and the memory macro.

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_lat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory-port arbiter: FSM states, grant encoding
// and the latency bound.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_LD   = 2'd2
  } grant_t;

  localparam int MEM_LAT_MAX = 3;
  localparam int LAT_CNT_W   = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core, loader and memory-macro signals around the arbiter.
// Handshake: a requester raises req with stable we/addr/wdata and holds all of
// them until the one-cycle ack; rdata is valid only while ack is high, and the
// requester may drop or change its request from the cycle after ack.
interface mem_port_arbiter_if #(
  parameter int AW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [7:0]    core_wdata;
  logic          core_lock;
  logic          core_ack;
  logic [7:0]    core_rdata;
  logic          core_wait;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_wdata;
  logic          ld_ack;
  logic [7:0]    ld_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [1:0]    grant;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_lock,
    output core_ack, core_rdata, core_wait,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output grant
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_lock,
    input  core_ack, core_rdata, core_wait,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  grant
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the WAIT phase of a memory access;
// tc is high once the count has reached zero.
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the byte-wide memory between the MIPS core and the program loader:
// core priority, core_lock for atomic fetch bursts, run counter against starvation.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW           = 8,
  parameter int MEM_LAT      = 1,
  parameter int MAX_CORE_RUN = 8
) (
  input  logic                clk_i_top,
  input  logic                rst_i_top,
  mem_port_arbiter_if.slave   bus,
  output arb_state_t          state_dbg,
  output logic [3:0]          run_cnt_dbg
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_CORE_RUN);
  // WAIT lasts MEM_LAT-1 cycles; the counter is loaded in ISSUE and WAIT exits at zero.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
    (MEM_LAT > 1) ? LAT_CNT_W'(MEM_LAT - 2) : '0;

  arb_state_t    state;
  grant_t        owner;
  logic [3:0]    run_cnt;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [7:0]    mem_wdata_q;
  logic          core_ack_q;
  logic          ld_ack_q;
  logic [7:0]    core_rdata_q;
  logic [7:0]    ld_rdata_q;
  logic          ld_win;
  logic          core_win;
  logic          lat_tc;

  always_comb begin
    ld_win   = bus.ld_req & ~bus.core_lock & (~bus.core_req | (run_cnt == RUN_MAX));
    core_win = ~ld_win & bus.core_req;
  end

  mem_lat_counter #(
    .W (LAT_CNT_W)
  ) u_lat (
    .clk      (clk_i_top),
    .rst      (rst_i_top),
    .load     (state == ISSUE),
    .load_val (LAT_LOAD),
    .dec      (state == WAIT),
    .tc       (lat_tc)
  );

  always_ff @(posedge clk_i_top) begin
    if (rst_i_top) begin
      state        <= IDLE;
      owner        <= GNT_NONE;
      run_cnt      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      core_ack_q   <= 1'b0;
      ld_ack_q     <= 1'b0;
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      core_ack_q <= 1'b0;
      ld_ack_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_win) begin
            state       <= ISSUE;
            owner       <= GNT_LD;
            run_cnt     <= '0;
            mem_addr_q  <= bus.ld_addr;
            mem_we_q    <= bus.ld_we;
            mem_wdata_q <= bus.ld_wdata;
          end else if (core_win) begin
            state       <= ISSUE;
            owner       <= GNT_CORE;
            mem_addr_q  <= bus.core_addr;
            mem_we_q    <= bus.core_we;
            mem_wdata_q <= bus.core_wdata;
            if (!bus.ld_req) begin
              run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
              run_cnt <= run_cnt + 4'd1;
            end
          end else begin
            owner <= GNT_NONE;
            // A loader held off by core_lock keeps its accumulated run count.
            if (!bus.ld_req) begin
              run_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          if (MEM_LAT > 1) begin
            state <= WAIT;
          end else begin
            state      <= DONE;
            core_ack_q <= (owner == GNT_CORE);
            ld_ack_q   <= (owner == GNT_LD);
          end
        end
        WAIT: begin
          if (lat_tc) begin
            state      <= DONE;
            core_ack_q <= (owner == GNT_CORE);
            ld_ack_q   <= (owner == GNT_LD);
          end
        end
        DONE: begin
          state <= IDLE;
          owner <= GNT_NONE;
          if (core_ack_q) begin
            core_rdata_q <= bus.mem_rdata;
          end
          if (ld_ack_q) begin
            ld_rdata_q <= bus.mem_rdata;
          end
        end
        default: begin
          state <= IDLE;
          owner <= GNT_NONE;
        end
      endcase
    end
  end

  // Read data passes straight through in DONE and is held afterwards.
  assign bus.core_ack   = core_ack_q;
  assign bus.core_rdata = core_ack_q ? bus.mem_rdata : core_rdata_q;
  assign bus.core_wait  = bus.core_req & ~core_ack_q;
  assign bus.ld_ack     = ld_ack_q;
  assign bus.ld_rdata   = ld_ack_q ? bus.mem_rdata : ld_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.grant      = owner;
  assign state_dbg      = state;
  assign run_cnt_dbg    = run_cnt;

endmodule
